dma_config_initiator: RTL and testbench

- CPU-side bus initiator that programs one DMA channel over the shared I/O register bus: address[3:0], data, IOR, IOW.
- On a start pulse it latches a configuration set and issues a fixed sequence of I/O write cycles to the DMA register file. The sequence covers the command, byte-pointer clear, mode, base address, word count and mask registers.
- It checks the command register's command_writed acknowledge and reports busy, done and error to the local controller.

---
 rtl/dma_config_initiator.sv | 151 +++++++++++++++
 tb/tb_dma_config_initiator.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_config_initiator.sv
// Programs one DMA channel: on start, latches a configuration and issues eight
// I/O write cycles (command, flip-flop clear, mode, base, count, mask).
module dma_config_initiator #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        start,
    input  logic [7:0]  cfg_command,
    input  logic [7:0]  cfg_mode,
    input  logic [1:0]  cfg_channel,
    input  logic [15:0] cfg_base_addr,
    input  logic [15:0] cfg_word_count,
    input  logic        command_writed,
    output logic [3:0]  address,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        IOR,
    output logic        IOW,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, NEXT, FINISH} state_t;

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        ack, ack_nxt;
    logic        err, err_nxt;
    logic        load;

    logic [7:0]  command_q;
    logic [7:0]  mode_q;
    logic [1:0]  channel_q;
    logic [15:0] base_q;
    logic [15:0] count_q;

    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        in_write;

    always_ff @(posedge clk) begin
        if (!RESET) begin
            state <= IDLE;
            idx   <= 3'd0;
            cnt   <= 4'd0;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            ack   <= ack_nxt;
            err   <= err_nxt;
        end
    end

    // Configuration is data only; it is qualified by the FSM state.
    always_ff @(posedge clk) begin
        if (load) begin
            command_q <= cfg_command;
            mode_q    <= cfg_mode;
            channel_q <= cfg_channel;
            base_q    <= cfg_base_addr;
            count_q   <= cfg_word_count;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        ack_nxt   = ack;
        err_nxt   = err;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    err_nxt   = 1'b0;
                    ack_nxt   = 1'b0;
                    idx_nxt   = 3'd0;
                    cnt_nxt   = 4'd0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cnt_nxt   = 4'd0;
                state_nxt = STROBE;
            end
            STROBE: begin
                if (idx == 3'd0 && command_writed)
                    ack_nxt = 1'b1;
                if (cnt == STROBE_LAST)
                    state_nxt = HOLD;
                else
                    cnt_nxt = cnt + 4'd1;
            end
            HOLD: begin
                // The ack may still arrive on the final HOLD edge, so include it here.
                if (idx == 3'd0 && !(ack || command_writed)) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if ((idx == 3'd0 && command_q[2]) || idx == 3'd7) begin
                    state_nxt = FINISH;
                end else begin
                    idx_nxt   = idx + 3'd1;
                    state_nxt = SETUP;
                end
            end
            NEXT: begin
                idx_nxt   = idx + 3'd1;
                state_nxt = SETUP;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_addr = 4'hA;
        wr_data = {6'b0, channel_q};
        case (idx)
            3'd0: begin wr_addr = 4'h8; wr_data = command_q; end
            3'd1: begin wr_addr = 4'hC; wr_data = 8'h00; end
            3'd2: begin wr_addr = 4'hB; wr_data = (mode_q & 8'hFC) | {6'b0, channel_q}; end
            3'd3: begin wr_addr = {1'b0, channel_q, 1'b0}; wr_data = base_q[7:0]; end
            3'd4: begin wr_addr = {1'b0, channel_q, 1'b0}; wr_data = base_q[15:8]; end
            3'd5: begin wr_addr = {1'b0, channel_q, 1'b1}; wr_data = count_q[7:0]; end
            3'd6: begin wr_addr = {1'b0, channel_q, 1'b1}; wr_data = count_q[15:8]; end
            default: begin wr_addr = 4'hA; wr_data = {6'b0, channel_q}; end
        endcase
    end

    always_comb begin
        in_write = (state == SETUP) || (state == STROBE) || (state == HOLD);
        address  = in_write ? wr_addr : 4'h0;
        data_out = in_write ? wr_data : 8'h00;
        data_oe  = in_write;
        IOR      = 1'b1;
        IOW      = (state != STROBE);
        busy     = in_write;
        done     = (state == FINISH);
        error    = err;
    end

endmodule

// File: tb/tb_dma_config_initiator.sv
// Bench for dma_config_initiator: a cycle-level model checks two instances
// (STROBE_CYCLES 2 and 1) every cycle, plus literal checks of the bus writes.
module tb_dma_config_initiator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        RESET, start, command_writed;
    logic [7:0]  cfg_command, cfg_mode;
    logic [1:0]  cfg_channel;
    logic [15:0] cfg_base_addr, cfg_word_count;

    logic [3:0] address_a, address_b;
    logic [7:0] data_a, data_b;
    logic       oe_a, oe_b, ior_a, ior_b, iow_a, iow_b;
    logic       busy_a, busy_b, done_a, done_b, err_a, err_b;

    dma_config_initiator #(.STROBE_CYCLES(2)) u_a (
        .clk(clk), .RESET(RESET), .start(start),
        .cfg_command(cfg_command), .cfg_mode(cfg_mode), .cfg_channel(cfg_channel),
        .cfg_base_addr(cfg_base_addr), .cfg_word_count(cfg_word_count),
        .command_writed(command_writed),
        .address(address_a), .data_out(data_a), .data_oe(oe_a),
        .IOR(ior_a), .IOW(iow_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    dma_config_initiator #(.STROBE_CYCLES(1)) u_b (
        .clk(clk), .RESET(RESET), .start(start),
        .cfg_command(cfg_command), .cfg_mode(cfg_mode), .cfg_channel(cfg_channel),
        .cfg_base_addr(cfg_base_addr), .cfg_word_count(cfg_word_count),
        .command_writed(command_writed),
        .address(address_b), .data_out(data_b), .data_oe(oe_b),
        .IOR(ior_b), .IOW(iow_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    // {IOR, IOW, address, data_out, data_oe, busy, done, error}
    logic [17:0] obs [2];
    always_comb begin
        obs[0] = {ior_a, iow_a, address_a, data_a, oe_a, busy_a, done_a, err_a};
        obs[1] = {ior_b, iow_b, address_b, data_b, oe_b, busy_b, done_b, err_b};
    end

    int vecs = 0;
    int miscompares = 0;

    // Model state: a programming run is "cycle k of the sequence" since the start edge.
    bit          m_run [2];
    bit          m_fin [2];
    bit          m_err [2];
    bit          m_ack [2];
    bit          m_dis [2];
    int          m_k [2];
    int          m_since [2];
    logic [11:0] m_tab [2][8];

    logic [11:0] log_a [$];
    logic [11:0] log_b [$];
    int          done_cnt [2];
    int          last_lat [2];
    bit          prev_iow [2];

    function automatic int strobes(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic logic [11:0] spec_write(int i, logic [7:0] cmd, logic [7:0] mode,
                                               logic [1:0] ch, logic [15:0] base, logic [15:0] cnt);
        case (i)
            0:       return {4'h8, cmd};
            1:       return {4'hC, 8'h00};
            2:       return {4'hB, mode[7:2], ch};
            3:       return {1'b0, ch, 1'b0, base[7:0]};
            4:       return {1'b0, ch, 1'b0, base[15:8]};
            5:       return {1'b0, ch, 1'b1, cnt[7:0]};
            6:       return {1'b0, ch, 1'b1, cnt[15:8]};
            default: return {4'hA, 6'b0, ch};
        endcase
    endfunction

    task automatic model();
        int per, last;
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                per = strobes(d) + 2;
                m_since[d]++;
                if (!RESET) begin
                    m_run[d] = 1'b0;
                    m_fin[d] = 1'b0;
                    m_err[d] = 1'b0;
                end else if (m_run[d]) begin
                    if (m_k[d] >= 1 && m_k[d] < per && command_writed)
                        m_ack[d] = 1'b1;
                    last = (m_dis[d] ? 1 : 8) * per - 1;
                    if (m_k[d] == per - 1 && !m_ack[d]) begin
                        m_run[d] = 1'b0;
                        m_err[d] = 1'b1;
                    end else if (m_k[d] == last) begin
                        m_run[d] = 1'b0;
                        m_fin[d] = 1'b1;
                    end else begin
                        m_k[d]++;
                    end
                end else if (m_fin[d]) begin
                    m_fin[d] = 1'b0;
                end else if (start) begin
                    m_run[d]   = 1'b1;
                    m_k[d]     = 0;
                    m_since[d] = 0;
                    m_err[d]   = 1'b0;
                    m_ack[d]   = 1'b0;
                    m_dis[d]   = cfg_command[2];
                    for (int i = 0; i < 8; i++)
                        m_tab[d][i] = spec_write(i, cfg_command, cfg_mode, cfg_channel,
                                                 cfg_base_addr, cfg_word_count);
                end
            end
        end
    endtask

    task automatic monitor();
        logic [17:0] exp;
        logic [11:0] t;
        int per, w, p;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                per = strobes(d) + 2;
                if (m_run[d]) begin
                    w   = m_k[d] / per;
                    p   = m_k[d] % per;
                    t   = m_tab[d][w];
                    exp = {1'b1, !(p >= 1 && p <= strobes(d)), t[11:8], t[7:0],
                           1'b1, 1'b1, 1'b0, m_err[d]};
                end else begin
                    exp = {1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, m_fin[d], m_err[d]};
                end
                vecs++;
                if (obs[d] !== exp) begin
                    miscompares++;
                    $display("FAIL cycle_bus dut%0d t=%0t actual=%h required=%h", d, $time, obs[d], exp);
                end
                if (!obs[d][16] && prev_iow[d]) begin
                    if (d == 0) log_a.push_back(obs[d][15:4]);
                    else        log_b.push_back(obs[d][15:4]);
                end
                prev_iow[d] = obs[d][16];
                if (obs[d][1]) begin
                    done_cnt[d]++;
                    last_lat[d] = m_since[d];
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int req);
        vecs++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int log_at(int d, int i);
        if (d == 0) return (i < log_a.size()) ? int'(log_a[i]) : -1;
        return (i < log_b.size()) ? int'(log_b[i]) : -1;
    endfunction

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        run(1);
        start = 1'b0;
    endtask

    task automatic set_cfg(input logic [7:0] cmd, input logic [7:0] mode, input logic [1:0] ch,
                           input logic [15:0] base, input logic [15:0] cnt);
        cfg_command    = cmd;
        cfg_mode       = mode;
        cfg_channel    = ch;
        cfg_base_addr  = base;
        cfg_word_count = cnt;
    endtask

    logic [11:0] full_a [8] = '{12'h8C1, 12'hC00, 12'hB49, 12'h234, 12'h212, 12'h3FF, 12'h300, 12'hA01};
    logic [11:0] full_b [8] = '{12'h881, 12'hC00, 12'hB03, 12'h6CD, 12'h6AB, 12'h778, 12'h756, 12'hA03};

    int mark_a, mark_b, dc_a, dc_b;

    initial begin
        RESET = 1'b0;
        start = 1'b0;
        command_writed = 1'b0;
        set_cfg(8'h00, 8'h00, 2'd0, 16'h0000, 16'h0000);
        fork
            model();
            monitor();
        join_none

        run(3);
        chk("reset_iow", int'(iow_a), 1);
        chk("reset_ior", int'(ior_a), 1);
        chk("reset_addr", int'(address_a), 0);
        chk("reset_busy_err", int'({busy_a, err_a, oe_a}), 0);
        RESET = 1'b1;
        run(2);

        // Full sequence, ack given.
        set_cfg(8'hC1, 8'h48, 2'd1, 16'h1234, 16'h00FF);
        command_writed = 1'b1;
        mark_a = log_a.size(); dc_a = done_cnt[0]; dc_b = done_cnt[1];
        pulse_start();
        run(40);
        chk("t1_nwrites", log_a.size() - mark_a, 8);
        for (int i = 0; i < 8; i++) chk("t1_write", log_at(0, mark_a + i), int'(full_a[i]));
        chk("t1_done_cnt", done_cnt[0] - dc_a, 1);
        chk("t1_done_lat", last_lat[0], 32);
        chk("t1_done_lat_sc1", last_lat[1], 24);
        chk("t1_error", int'(err_a), 0);

        // Disable command: single write, done after 4 cycles.
        set_cfg(8'h04, 8'h48, 2'd1, 16'h1234, 16'h00FF);
        mark_a = log_a.size(); dc_a = done_cnt[0];
        pulse_start();
        run(12);
        chk("t2_nwrites", log_a.size() - mark_a, 1);
        chk("t2_write", log_at(0, mark_a), 12'h804);
        chk("t2_done_cnt", done_cnt[0] - dc_a, 1);
        chk("t2_done_lat", last_lat[0], 4);

        // No acknowledge: error, no done.
        set_cfg(8'hC1, 8'h48, 2'd1, 16'h1234, 16'h00FF);
        command_writed = 1'b0;
        mark_a = log_a.size(); dc_a = done_cnt[0];
        pulse_start();
        run(12);
        chk("t3_error", int'(err_a), 1);
        chk("t3_busy", int'(busy_a), 0);
        chk("t3_nwrites", log_a.size() - mark_a, 1);
        chk("t3_no_done", done_cnt[0] - dc_a, 0);
        command_writed = 1'b1;
        pulse_start();
        chk("t3_error_cleared", int'(err_a), 0);
        run(40);

        // start while busy at index 3 is ignored.
        set_cfg(8'hC1, 8'h48, 2'd1, 16'h1234, 16'h00FF);
        mark_a = log_a.size(); dc_a = done_cnt[0];
        pulse_start();
        run(12);
        start = 1'b1;
        run(1);
        start = 1'b0;
        run(30);
        chk("t4_nwrites", log_a.size() - mark_a, 8);
        for (int i = 0; i < 8; i++) chk("t4_write", log_at(0, mark_a + i), int'(full_a[i]));
        chk("t4_done_cnt", done_cnt[0] - dc_a, 1);

        // Reset during STROBE of index 4, then a clean run.
        pulse_start();
        run(17);
        chk("t5_in_strobe4", int'({iow_a, address_a}), 5'h02);
        RESET = 1'b0;
        run(1);
        chk("t5_reset_bus", int'({ior_a, iow_a, address_a, oe_a}), 7'h60);
        chk("t5_reset_ctl", int'({busy_a, err_a}), 0);
        RESET = 1'b1;
        run(3);
        mark_a = log_a.size(); dc_a = done_cnt[0];
        pulse_start();
        run(40);
        chk("t5_nwrites", log_a.size() - mark_a, 8);
        for (int i = 0; i < 8; i++) chk("t5_write", log_at(0, mark_a + i), int'(full_a[i]));
        chk("t5_done_cnt", done_cnt[0] - dc_a, 1);

        // Channel 3, checked on the one-cycle-strobe instance.
        set_cfg(8'h81, 8'h00, 2'd3, 16'hABCD, 16'h5678);
        mark_b = log_b.size(); dc_b = done_cnt[1];
        pulse_start();
        run(40);
        chk("t6_nwrites", log_b.size() - mark_b, 8);
        for (int i = 0; i < 8; i++) chk("t6_write", log_at(1, mark_b + i), int'(full_b[i]));
        chk("t6_done_cnt", done_cnt[1] - dc_b, 1);
        chk("t6_done_lat", last_lat[1], 24);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
